// File: rtl/imem_refill_ctrl.sv
// I-cache miss handler: detects a fetch miss, issues one line read, and writes
// the returned beats into the data array before installing the tag.
module imem_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              tag_hit,
  input  logic              redirect,
  output logic              imem_miss,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              refill_we,
  output logic [ADDR_W-1:0] refill_addr,
  output logic [31:0]       refill_data,
  output logic              refill_tag_we,
  output logic              refill_done
);

  localparam int                BEAT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic                r_squash;
  logic                w_squash_nxt;
  logic [ADDR_W-1:0]   r_line_addr;
  logic [ADDR_W-1:0]   w_line_addr_nxt;
  logic                w_miss_det;

  assign w_miss_det    = fetch_valid & ~tag_hit & ~redirect;
  assign mem_req_addr  = r_line_addr;
  assign refill_addr   = r_line_addr + ADDR_W'({r_beat, 2'b00});
  assign refill_data   = mem_rsp_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_squash    <= 1'b0;
      r_line_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_squash    <= w_squash_nxt;
      r_line_addr <= w_line_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_squash_nxt    = r_squash;
    w_line_addr_nxt = r_line_addr;
    imem_miss       = 1'b1;
    mem_req_valid   = 1'b0;
    refill_we       = 1'b0;
    refill_tag_we   = 1'b0;
    refill_done     = 1'b0;
    case (r_state)
      IDLE: begin
        imem_miss = w_miss_det;
        if (w_miss_det) begin
          w_line_addr_nxt = fetch_addr & ~OFFS_MASK;
          w_squash_nxt    = 1'b0;
          w_state_nxt     = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (redirect) w_squash_nxt = 1'b1;
        if (mem_req_ready) begin
          w_beat_nxt  = '0;
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        // A flush only cancels the retry pulse; the bus burst always drains.
        if (redirect) w_squash_nxt = 1'b1;
        if (mem_rsp_valid) begin
          refill_we  = 1'b1;
          w_beat_nxt = r_beat + BEAT_W'(1);
          if (r_beat == LAST_BEAT) begin
            refill_tag_we = 1'b1;
            w_beat_nxt    = '0;
            w_state_nxt   = DONE;
          end
        end
      end
      DONE: begin
        refill_done = ~r_squash & ~redirect;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
